// File: rtl/pattern_player_pkg.sv
// Shared definitions for the pattern player: state encoding, default timing,
// and the level/code decode helpers used by the RTL and any checkers.
package pattern_player_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int DEF_ON_CYCLES  = 3;
   localparam int DEF_OFF_CYCLES = 2;

   // Sequence length is 4, 8, 12 or 16 entries for level 0..3.
   function automatic logic [4:0] seq_len(input logic [1:0] lvl);
      return {1'b0, lvl, 2'b00} + 5'd4;
   endfunction

   function automatic logic [7:0] code_onehot(input logic [2:0] code);
      return 8'b0000_0001 << code;
   endfunction

endpackage

// File: rtl/pattern_player_phase_timer.sv
// Loadable 8-bit down-counter; o_tc flags the last cycle of the current phase.
module phase_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_load,
   input  logic [7:0] i_load_val,
   output logic       o_tc
);

   logic [7:0] r_count;

   // Holds at zero rather than wrapping if a phase is left open.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 8'd0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != 8'd0) begin
         r_count <= r_count - 8'd1;
      end
   end

   assign o_tc = (r_count == 8'd0);

endmodule

// File: rtl/pattern_player.sv
// Plays back a latched list of button codes on a one-hot LED bus, each code
// shown for ON_CYCLES then blanked for OFF_CYCLES, with a done pulse at the end.
module pattern_player
   import pattern_player_pkg::*;
#(
   parameter int ON_CYCLES  = DEF_ON_CYCLES,
   parameter int OFF_CYCLES = DEF_OFF_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] level,
   input  logic       start,
   input  logic       abort,
   input  logic [2:0] pattern_1,
   input  logic [2:0] pattern_2,
   input  logic [2:0] pattern_3,
   input  logic [2:0] pattern_4,
   input  logic [2:0] pattern_5,
   input  logic [2:0] pattern_6,
   input  logic [2:0] pattern_7,
   input  logic [2:0] pattern_8,
   input  logic [2:0] pattern_9,
   input  logic [2:0] pattern_10,
   input  logic [2:0] pattern_11,
   input  logic [2:0] pattern_12,
   input  logic [2:0] pattern_13,
   input  logic [2:0] pattern_14,
   input  logic [2:0] pattern_15,
   input  logic [2:0] pattern_16,
   output logic [7:0] led,
   output logic [3:0] idx,
   output logic       busy,
   output logic       done,
   output state_t     o_dbg_state
);

   // The timer counts down to zero, so each phase loads its length minus one.
   localparam logic [7:0] ON_LOAD  = 8'(ON_CYCLES - 1);
   localparam logic [7:0] OFF_LOAD = 8'(OFF_CYCLES - 1);

   state_t     r_state;
   logic [1:0] r_level;
   logic [2:0] r_pat [16];
   logic [7:0] r_led;
   logic [3:0] r_idx;
   logic       r_busy;
   logic       r_done;

   logic [2:0] w_pat_in [16];
   logic       w_tc;
   logic       w_load;
   logic [7:0] w_load_val;
   logic       w_last;
   logic       w_go;

   assign w_pat_in[0]  = pattern_1;
   assign w_pat_in[1]  = pattern_2;
   assign w_pat_in[2]  = pattern_3;
   assign w_pat_in[3]  = pattern_4;
   assign w_pat_in[4]  = pattern_5;
   assign w_pat_in[5]  = pattern_6;
   assign w_pat_in[6]  = pattern_7;
   assign w_pat_in[7]  = pattern_8;
   assign w_pat_in[8]  = pattern_9;
   assign w_pat_in[9]  = pattern_10;
   assign w_pat_in[10] = pattern_11;
   assign w_pat_in[11] = pattern_12;
   assign w_pat_in[12] = pattern_13;
   assign w_pat_in[13] = pattern_14;
   assign w_pat_in[14] = pattern_15;
   assign w_pat_in[15] = pattern_16;

   assign w_go   = start && !abort;
   assign w_last = ({1'b0, r_idx} == (seq_len(r_level) - 5'd1));

   // Reload the timer on every state change so no phase inherits a stale count.
   always_comb begin
      w_load     = 1'b0;
      w_load_val = 8'd0;
      case (r_state)
         ST_IDLE: if (w_go) begin
            w_load     = 1'b1;
            w_load_val = ON_LOAD;
         end
         ST_SHOW: if (abort || w_tc) begin
            w_load     = 1'b1;
            w_load_val = abort ? 8'd0 : OFF_LOAD;
         end
         ST_GAP: if (abort || w_tc) begin
            w_load     = 1'b1;
            w_load_val = (abort || w_last) ? 8'd0 : ON_LOAD;
         end
         default: w_load = 1'b1;
      endcase
   end

   phase_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_tc       (w_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_level <= 2'd0;
         r_led   <= 8'd0;
         r_idx   <= 4'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         for (int i = 0; i < 16; i++) r_pat[i] <= 3'd0;
      end else if (r_state != ST_IDLE && abort) begin
         r_state <= ST_IDLE;
         r_led   <= 8'd0;
         r_idx   <= 4'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_go) begin
               r_state <= ST_SHOW;
               r_level <= level;
               for (int i = 0; i < 16; i++) r_pat[i] <= w_pat_in[i];
               r_idx   <= 4'd0;
               r_led   <= code_onehot(pattern_1);
               r_busy  <= 1'b1;
               r_done  <= 1'b0;
            end
            ST_SHOW: if (w_tc) begin
               r_state <= ST_GAP;
               r_led   <= 8'd0;
            end
            ST_GAP: if (w_tc) begin
               if (w_last) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= ST_SHOW;
                  r_idx   <= r_idx + 4'd1;
                  r_led   <= code_onehot(r_pat[r_idx + 4'd1]);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_led   <= 8'd0;
               r_idx   <= 4'd0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign led         = r_led;
   assign idx         = r_idx;
   assign busy        = r_busy;
   assign done        = r_done;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pattern_player.sv
// Directed bench for pattern_player with ON=3, OFF=2: table-driven playbacks
// plus hand-written abort, reset, held-start and start/abort-together sequences.
module tb_pattern_player;
   import pattern_player_pkg::*;

   localparam int ON  = 3;
   localparam int OFF = 2;
   localparam int PER = ON + OFF;
   localparam int W   = 14;

   logic       clk;
   logic       rst;
   logic [1:0] level;
   logic       start;
   logic       abort;
   logic [2:0] pat_in [16];
   logic [7:0] led;
   logic [3:0] idx;
   logic       busy;
   logic       done;
   state_t     dbg_state;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q [$];

   typedef struct {
      string      name;
      logic [1:0] lvl;
      logic [2:0] pat [16];
      bit         disturb;
   } vec_t;

   vec_t vecs [4];

   pattern_player #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
      .clk(clk), .rst(rst), .level(level), .start(start), .abort(abort),
      .pattern_1(pat_in[0]),   .pattern_2(pat_in[1]),   .pattern_3(pat_in[2]),
      .pattern_4(pat_in[3]),   .pattern_5(pat_in[4]),   .pattern_6(pat_in[5]),
      .pattern_7(pat_in[6]),   .pattern_8(pat_in[7]),   .pattern_9(pat_in[8]),
      .pattern_10(pat_in[9]),  .pattern_11(pat_in[10]), .pattern_12(pat_in[11]),
      .pattern_13(pat_in[12]), .pattern_14(pat_in[13]), .pattern_15(pat_in[14]),
      .pattern_16(pat_in[15]),
      .led(led), .idx(idx), .busy(busy), .done(done), .o_dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [W-1:0] pack(input logic [7:0] l, input logic [3:0] i,
                                          input logic b, input logic d);
      return {l, i, b, d};
   endfunction

   function automatic logic [W-1:0] actual();
      return {led, idx, busy, done};
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got led=%02h idx=%0d busy=%0b done=%0b, expected led=%02h idx=%0d busy=%0b done=%0b",
                  name, act[13:6], act[5:2], act[1], act[0], exp[13:6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic drive_pats(input logic [2:0] p [16]);
      for (int i = 0; i < 16; i++) pat_in[i] = p[i];
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int max_cycles);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check_bit({name, "_idle_timeout"}, busy, 1'b0);
      @(negedge clk);
   endtask

   // Expected trace from the display timing: entry c/PER is shown for the first
   // ON cycles of each slot, done lands at LEN*PER, idle one cycle later.
   task automatic build_expect(input vec_t v);
      int len;
      len = 4 * (int'(v.lvl) + 1);
      exp_q.delete();
      for (int c = 0; c <= len * PER + 1; c++) begin
         if (c < len * PER) begin
            exp_q.push_back(pack(((c % PER) < ON) ? (8'd1 << v.pat[c / PER]) : 8'd0,
                                 4'(c / PER), 1'b1, 1'b0));
         end else if (c == len * PER) begin
            exp_q.push_back(pack(8'd0, 4'(len - 1), 1'b1, 1'b1));
         end else begin
            exp_q.push_back(pack(8'd0, 4'd0, 1'b0, 1'b0));
         end
      end
   endtask

   task automatic play_vec(input vec_t v);
      logic [W-1:0] e;
      int c;
      build_expect(v);
      drive_pats(v.pat);
      level = v.lvl;
      pulse_start();
      c = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         check($sformatf("%s_c%0d", v.name, c), actual(), e);
         total++;
         if ($countones(led) > 1) begin
            bad++;
            $display("FAIL %s_onehot_c%0d: got led=%02h expected one-hot or zero", v.name, c, led);
         end
         if (v.disturb && c == 2) begin
            level     = 2'd0;
            pat_in[0] = 3'd5;
            start     = 1'b1;
         end
         if (v.disturb && c == 4) start = 1'b0;
         c++;
      end
   endtask

   initial begin
      logic [2:0] p [16];
      int n;

      rst   = 1'b1;
      level = 2'd0;
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < 16; i++) pat_in[i] = 3'(i);

      #1;
      check("reset_outputs", actual(), pack(8'd0, 4'd0, 1'b0, 1'b0));
      check_bit("reset_state_idle", dbg_state == ST_IDLE, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      vecs[0].name = "lvl0_inc";
      vecs[0].lvl  = 2'd0;
      vecs[0].disturb = 1'b0;
      for (int i = 0; i < 16; i++) vecs[0].pat[i] = 3'(i < 4 ? i : $urandom_range(0, 7));
      vecs[1].name = "lvl3_dec";
      vecs[1].lvl  = 2'd3;
      vecs[1].disturb = 1'b0;
      for (int i = 0; i < 16; i++) vecs[1].pat[i] = 3'(7 - (i % 8));
      vecs[2].name = "lvl2_disturb";
      vecs[2].lvl  = 2'd2;
      vecs[2].disturb = 1'b1;
      for (int i = 0; i < 16; i++) vecs[2].pat[i] = 3'((i * 5 + 2) % 8);
      vecs[3].name = "lvl1_mix";
      vecs[3].lvl  = 2'd1;
      vecs[3].disturb = 1'b0;
      for (int i = 0; i < 16; i++) vecs[3].pat[i] = 3'((3 * i + 1) % 8);

      for (int v = 0; v < 4; v++) begin
         play_vec(vecs[v]);
         @(negedge clk);
      end

      // abort during a level-1 playback, then restart from entry 1
      for (int i = 0; i < 16; i++) p[i] = 3'((i + 2) % 8);
      drive_pats(p);
      level = 2'd1;
      pulse_start();
      for (int c = 0; c <= 11; c++) begin
         @(negedge clk);
         if (c == 7) begin
            check("abort_pre", actual(), pack(8'd1 << p[1], 4'd1, 1'b1, 1'b0));
            abort = 1'b1;
         end
         if (c == 8) begin
            check("abort_cleared", actual(), pack(8'd0, 4'd0, 1'b0, 1'b0));
            check_bit("abort_state_idle", dbg_state == ST_IDLE, 1'b1);
            abort = 1'b0;
         end
         if (c == 9) begin
            check("abort_no_done", actual(), pack(8'd0, 4'd0, 1'b0, 1'b0));
            start = 1'b1;
         end
         if (c == 10) begin
            check("abort_restart", actual(), pack(8'd1 << p[0], 4'd0, 1'b1, 1'b0));
            start = 1'b0;
         end
         if (c == 11) check("abort_restart_hold", actual(), pack(8'd1 << p[0], 4'd0, 1'b1, 1'b0));
      end
      wait_idle("abort_replay", 60);

      // asynchronous reset in the middle of a SHOW cycle
      level = 2'd0;
      pulse_start();
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_show", actual(), pack(8'd1 << pat_in[0], 4'd0, 1'b1, 1'b0));
      #1 rst = 1'b1;
      #1;
      check("async_rst_immediate", actual(), pack(8'd0, 4'd0, 1'b0, 1'b0));
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0) n++;
      end
      total++;
      if (n != 0) begin
         bad++;
         $display("FAIL post_rst_quiet: got %0d active cycles expected 0", n);
      end

      // start held high: back-to-back playbacks with one idle cycle between
      for (int i = 0; i < 16; i++) p[i] = 3'(i % 4);
      drive_pats(p);
      level = 2'd0;
      start = 1'b1;
      @(posedge clk);
      for (int c = 0; c <= 45; c++) begin
         @(negedge clk);
         if (c == 0)  check("held_first", actual(), pack(8'h01, 4'd0, 1'b1, 1'b0));
         if (c == 20) check("held_done1", actual(), pack(8'h00, 4'd3, 1'b1, 1'b1));
         if (c == 21) check("held_idle_gap", actual(), pack(8'h00, 4'd0, 1'b0, 1'b0));
         if (c == 22) check("held_second", actual(), pack(8'h01, 4'd0, 1'b1, 1'b0));
         if (c == 42) check("held_done2", actual(), pack(8'h00, 4'd3, 1'b1, 1'b1));
      end
      start = 1'b0;
      wait_idle("held_tail", 40);

      // start and abort together in IDLE never launch a playback
      start = 1'b1;
      abort = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("start_abort_c%0d", c), actual(), pack(8'd0, 4'd0, 1'b0, 1'b0));
      end
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
